alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Sole controller of the 16-bit logic_unit datapath. Accepts one operation request at a time (valid/ready),
//  drives the logic_unit one-hot select lines and operand buses, and captures the result plus Z/N/C/V flags.
//  Adds a multi-cycle MUL op (iterative shift-add, reusing the logic_unit adder). Returns the response on a
//  valid/ready channel. Sits between instruction decode/execute control and the logic_unit instance.
// PARAMETERS
//  WIDTH          16  datapath width; must match logic_unit (bus1/bus2/bus3)
//  MUL_EARLY_EXIT 1   1: MUL stops once remaining multiplier bits are 0; 0: always WIDTH iterations
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous reset, active low
//  req_valid      in   1      request present
//  req_ready      out  1      high only in IDLE
//  req_op         in   4      0 PASS,1 ADD,2 SUB,3 SHR,4 SHL,5 AND,6 OR,7 XOR,8 NOT,9 MUL; 10-15 illegal
//  req_a, req_b   in   WIDTH  operands (A=bus1, B=bus2)
//  rsp_valid      out  1      response present; held until rsp_ready
//  rsp_ready      in   1      consumer accepts response
//  rsp_data       out  WIDTH  result
//  rsp_flags      out  4      {Z,N,C,V}
//  rsp_err        out  1      illegal opcode
//  alu_passthrough,alu_add,alu_sub,alu_shr,alu_shl,alu_band,alu_bor,alu_bxor,alu_bnegate  out 1 each
//  alu_bus1, alu_bus2  out  WIDTH  operands to logic_unit
//  alu_bus3       in   WIDTH  logic_unit result
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; req_ready=1 after release; rsp_valid/rsp_err/all alu_* selects=0;
//    rsp_data, rsp_flags, alu_bus1/2, internal regs=0. Reset mid-op aborts it; no response is produced.
//  - alu_passthrough is tied 0 (its feedback path is unusable); PASS: result=A internally, no select.
//  - At most one select high in any cycle; all selects 0 outside EXEC/MUL. alu_bus1/2 registered.
//  - FSM: IDLE -> (req_valid&&req_ready at edge n) -> EXEC (legal non-MUL), MUL, or DONE (illegal).
//    EXEC: one cycle, select for latched op; edge n+1 captures alu_bus3 and flags -> DONE.
//    MUL: acc=0, mcand=A, mplr=B; per cycle alu_add with bus1=acc, bus2=mcand; if mplr[0] acc<=alu_bus3;
//    mcand<<=1; mplr>>=1; cnt++. Exit after cnt==WIDTH, or (MUL_EARLY_EXIT) when next mplr==0.
//    Minimum 1 iteration (B=0 -> 1 cycle, result 0). k iterations -> rsp_valid from edge n+k.
//    DONE: rsp_valid=1; rsp_* stable; on rsp_valid&&rsp_ready -> IDLE (new req earliest the next edge).
//  - Illegal op: DONE from edge n+1, rsp_err=1, rsp_data=0, flags=0, no select asserted.
//  - Width rules: result truncated to WIDTH. MUL returns low WIDTH bits of product.
//    SHR/SHL use full B as shift amount; B>=WIDTH -> 0.
//  - Flags: Z=(result==0), N=result[WIDTH-1] for all legal ops.
//    ADD: C=carry-out of A+B (computed internally, WIDTH+1 bits), V=signed overflow.
//    SUB: C=borrow (A<B unsigned), V=signed overflow. All other ops: C=0, V=0.
//  - req_valid while busy is ignored (req_ready=0); req_* sampled only at the accepting edge.
// STRUCTURE
//  - Shared header alu_defs.vh: opcode localparams, FSM state encodings (IDLE/EXEC/MUL/DONE),
//    flag bit indices (FLG_Z=3,FLG_N=2,FLG_C=1,FLG_V=0).
//  - One sub-module: alu_flag_gen (combinational; op, A, B, result -> {Z,N,C,V}).
//  - Decoder op->one-hot select and the MUL iterator live in alu_sequencer.
// TESTING
//  1 ADD A=0x7FFF B=0x0001 accepted edge n -> rsp_valid from n+1, data 0x8000, flags Z0 N1 C0 V1.
//  2 SUB A=0x0005 B=0x0005 -> 0x0000, Z1 N0 C0 V0; SUB 0x0000-0x0001 -> 0xFFFF, N1 C1 V0.
//  3 MUL 0x0003*0x0005 -> 0x000F after 3 iterations (rsp_valid n+3); MUL 0x0101*0xFFFF -> 0xFEFF after 16;
//    check alu_add high in every MUL cycle and no other select.
//  4 req_op=0xF -> rsp_err=1, data 0, flags 0, rsp_valid n+1, no alu_* select ever high.
//  5 Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* unchanged, req_ready=0; raise rsp_ready ->
//    IDLE; back-to-back req accepted the following edge. SHL A=0x0001 B=0x0010 -> 0x0000, Z1.
//  6 Assert rst_n=0 during MUL 0x1234*0xFFFF iteration 7 -> all outputs 0 immediately; release ->
//    req_ready=1, no stale rsp_valid; next ADD 0x0001+0x0002 returns 0x0003.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_pkg
//  Description : Shared opcodes, FSM states, flag indices and select helpers
//                for the logic_unit sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

    // Request opcodes; 10..15 are illegal
    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    // Flag bit positions inside {Z,N,C,V}
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Bit positions of the internal one-hot select vector
    localparam int SEL_ADD = 0;
    localparam int SEL_SUB = 1;
    localparam int SEL_SHR = 2;
    localparam int SEL_SHL = 3;
    localparam int SEL_AND = 4;
    localparam int SEL_OR  = 5;
    localparam int SEL_XOR = 6;
    localparam int SEL_NOT = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_MUL);
    endfunction

    // PASS, MUL and illegal opcodes return no select here; MUL drives ADD itself
    function automatic logic [7:0] sel_for_op(input logic [3:0] op);
        logic [7:0] s;
        s = 8'h00;
        case (op)
            OP_ADD:  s[SEL_ADD] = 1'b1;
            OP_SUB:  s[SEL_SUB] = 1'b1;
            OP_SHR:  s[SEL_SHR] = 1'b1;
            OP_SHL:  s[SEL_SHL] = 1'b1;
            OP_AND:  s[SEL_AND] = 1'b1;
            OP_OR:   s[SEL_OR]  = 1'b1;
            OP_XOR:  s[SEL_XOR] = 1'b1;
            OP_NOT:  s[SEL_NOT] = 1'b1;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

endpackage : alu_sequencer_pkg
`default_nettype wire

// File: rtl/alu_sequencer_flag_gen.sv
`default_nettype none
// ============================================================================
//  Module      : alu_flag_gen
//  Description : Combinational {Z,N,C,V} generation from op, operands, result.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_flag_gen
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] result_i,
    output logic [3:0]       flags_o
);

    logic [WIDTH-1:0] w_sum;

    // Carry-out of A+B shows up as the truncated sum wrapping below A
    assign w_sum = a_i + b_i;

    // Z/N for every op; C/V only meaningful for ADD and SUB
    always_comb begin
        flags_o        = 4'h0;
        flags_o[FLG_Z] = (result_i == '0);
        flags_o[FLG_N] = result_i[WIDTH-1];
        if (op_i == OP_ADD) begin
            flags_o[FLG_C] = (w_sum < a_i);
            flags_o[FLG_V] = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                             (result_i[WIDTH-1] != a_i[WIDTH-1]);
        end else if (op_i == OP_SUB) begin
            flags_o[FLG_C] = (a_i < b_i);
            flags_o[FLG_V] = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                             (result_i[WIDTH-1] != a_i[WIDTH-1]);
        end
    end

endmodule : alu_flag_gen
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Request/response controller for the 16-bit logic_unit,
//                including an iterative shift-add MUL on the unit's adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter bit MUL_EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic             alu_passthrough,
    output logic             alu_add,
    output logic             alu_sub,
    output logic             alu_shr,
    output logic             alu_shl,
    output logic             alu_band,
    output logic             alu_bor,
    output logic             alu_bxor,
    output logic             alu_bnegate,
    output logic [WIDTH-1:0] alu_bus1,
    output logic [WIDTH-1:0] alu_bus2,
    input  logic [WIDTH-1:0] alu_bus3
);

    localparam int              CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   N_ITR = CW'(WIDTH);
    localparam logic [WIDTH:0]  W_LIM = (WIDTH + 1)'(WIDTH);

    state_t           state_q;
    logic             ready_q, rsp_valid_q, rsp_err_q;
    logic [3:0]       op_q, rsp_flags_q;
    logic [WIDTH-1:0] a_q, b_q, rsp_data_q, bus1_q, bus2_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplr_q;
    logic [CW-1:0]    cnt_q;
    logic [7:0]       sel_q;

    logic [WIDTH-1:0] acc_d, mcand_d, mplr_d, result_d;
    logic [CW-1:0]    cnt_d;
    logic [3:0]       flags_d;
    logic             mul_last;

    // The passthrough feedback path is unusable; PASS is resolved internally
    assign alu_passthrough = 1'b0;
    assign alu_add         = sel_q[SEL_ADD];
    assign alu_sub         = sel_q[SEL_SUB];
    assign alu_shr         = sel_q[SEL_SHR];
    assign alu_shl         = sel_q[SEL_SHL];
    assign alu_band        = sel_q[SEL_AND];
    assign alu_bor         = sel_q[SEL_OR];
    assign alu_bxor        = sel_q[SEL_XOR];
    assign alu_bnegate     = sel_q[SEL_NOT];
    assign alu_bus1        = bus1_q;
    assign alu_bus2        = bus2_q;
    assign req_ready       = ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_flags       = rsp_flags_q;
    assign rsp_err         = rsp_err_q;

    // Next multiplier iteration state and the exit test for the MUL loop
    always_comb begin
        acc_d    = mplr_q[0] ? alu_bus3 : acc_q;
        mcand_d  = mcand_q << 1;
        mplr_d   = mplr_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        mul_last = (cnt_d == N_ITR) || (MUL_EARLY_EXIT && (mplr_d == '0));
    end

    // Result selection: PASS bypasses the unit, oversized shifts saturate to 0
    always_comb begin
        result_d = '0;
        if (state_q == ST_MUL) begin
            result_d = acc_d;
        end else begin
            case (op_q)
                OP_PASS:        result_d = a_q;
                OP_SHR, OP_SHL: result_d = ({1'b0, b_q} >= W_LIM) ? '0 : alu_bus3;
                default:        result_d = op_is_legal(op_q) ? alu_bus3 : '0;
            endcase
        end
    end

    alu_flag_gen #(
        .WIDTH    (WIDTH)
    ) u_flag_gen (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_i (result_d),
        .flags_o  (flags_d)
    );

    // Sequencer FSM with registered selects, operand buses and response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= 4'h0;
            op_q        <= 4'h0;
            a_q         <= '0;
            b_q         <= '0;
            bus1_q      <= '0;
            bus2_q      <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            cnt_q       <= '0;
            sel_q       <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        ready_q <= 1'b0;
                        op_q    <= req_op;
                        a_q     <= req_a;
                        b_q     <= req_b;
                        if (req_op == OP_MUL) begin
                            state_q <= ST_MUL;
                            acc_q   <= '0;
                            mcand_q <= req_a;
                            mplr_q  <= req_b;
                            cnt_q   <= '0;
                            bus1_q  <= '0;
                            bus2_q  <= req_a;
                            sel_q   <= 8'h01 << SEL_ADD;
                        end else begin
                            // Illegal ops also spend one EXEC cycle, with no select
                            state_q <= ST_EXEC;
                            bus1_q  <= req_a;
                            bus2_q  <= req_b;
                            sel_q   <= sel_for_op(req_op);
                        end
                    end
                end
                ST_EXEC: begin
                    state_q     <= ST_DONE;
                    sel_q       <= 8'h00;
                    rsp_valid_q <= 1'b1;
                    if (op_is_legal(op_q)) begin
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= result_d;
                        rsp_flags_q <= flags_d;
                    end else begin
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_flags_q <= 4'h0;
                    end
                end
                ST_MUL: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_d;
                    mplr_q  <= mplr_d;
                    cnt_q   <= cnt_d;
                    bus1_q  <= acc_d;
                    bus2_q  <= mcand_d;
                    if (mul_last) begin
                        state_q     <= ST_DONE;
                        sel_q       <= 8'h00;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= result_d;
                        rsp_flags_q <= flags_d;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer with a logic_unit
//                stand-in and a behavioural result/latency model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [3:0]    req_op, rsp_flags;
    logic [W-1:0]  req_a, req_b, rsp_data, alu_bus1, alu_bus2, alu_bus3;
    logic          alu_passthrough, alu_add, alu_sub, alu_shr, alu_shl;
    logic          alu_band, alu_bor, alu_bxor, alu_bnegate;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic          in_flight = 1'b0;
    logic [7:0]    exp_sel   = 8'h00;
    logic [7:0]    sels;

    always #5 clk = ~clk;

    assign sels = {alu_bnegate, alu_bxor, alu_bor, alu_band, alu_shl, alu_shr, alu_sub, alu_add};

    alu_sequencer #(
        .WIDTH           (W),
        .MUL_EARLY_EXIT  (1'b1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_a           (req_a),
        .req_b           (req_b),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_flags       (rsp_flags),
        .rsp_err         (rsp_err),
        .alu_passthrough (alu_passthrough),
        .alu_add         (alu_add),
        .alu_sub         (alu_sub),
        .alu_shr         (alu_shr),
        .alu_shl         (alu_shl),
        .alu_band        (alu_band),
        .alu_bor         (alu_bor),
        .alu_bxor        (alu_bxor),
        .alu_bnegate     (alu_bnegate),
        .alu_bus1        (alu_bus1),
        .alu_bus2        (alu_bus2),
        .alu_bus3        (alu_bus3)
    );

    // Stand-in for the logic_unit datapath
    always_comb begin
        alu_bus3 = '0;
        if (alu_add)          alu_bus3 = alu_bus1 + alu_bus2;
        else if (alu_sub)     alu_bus3 = alu_bus1 - alu_bus2;
        else if (alu_shr)     alu_bus3 = alu_bus1 >> alu_bus2;
        else if (alu_shl)     alu_bus3 = alu_bus1 << alu_bus2;
        else if (alu_band)    alu_bus3 = alu_bus1 & alu_bus2;
        else if (alu_bor)     alu_bus3 = alu_bus1 | alu_bus2;
        else if (alu_bxor)    alu_bus3 = alu_bus1 ^ alu_bus2;
        else if (alu_bnegate) alu_bus3 = ~alu_bus1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: result, {Z,N,C,V}, error and cycles from accept to rsp_valid
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] d, output logic [3:0] f,
                                  output logic e, output int lat);
        int     sa, sb, s;
        longint p;
        d = '0; f = 4'h0; e = 1'b0; lat = 1;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            4'd0: d = a;
            4'd1: begin
                d = a + b;
                f[1] = (int'(a) + int'(b)) > 65535;
                s = sa + sb;
                f[0] = (s > 32767) || (s < -32768);
            end
            4'd2: begin
                d = a - b;
                f[1] = (a < b);
                s = sa - sb;
                f[0] = (s > 32767) || (s < -32768);
            end
            4'd3: d = (int'(b) >= W) ? '0 : (a >> b);
            4'd4: d = (int'(b) >= W) ? '0 : (a << b);
            4'd5: d = a & b;
            4'd6: d = a | b;
            4'd7: d = a ^ b;
            4'd8: d = ~a;
            4'd9: begin
                p = longint'(a) * longint'(b);
                d = p[15:0];
                for (int i = 0; i < W; i++) if (b[i]) lat = i + 1;
            end
            default: e = 1'b1;
        endcase
        if (!e) begin
            f[3] = (d == '0);
            f[2] = d[W-1];
        end
    endfunction

    function automatic logic [7:0] sel_model(input logic [3:0] op);
        case (op)
            4'd1, 4'd9: return 8'h01;
            4'd2: return 8'h02;
            4'd3: return 8'h04;
            4'd4: return 8'h08;
            4'd5: return 8'h10;
            4'd6: return 8'h20;
            4'd7: return 8'h40;
            4'd8: return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    // Per-cycle select checks: passthrough never used, selects only while busy
    always @(negedge clk) begin
        if (rst_n) begin
            chk("passthrough", {31'd0, alu_passthrough}, 32'd0);
            chk("sel_onehot", {31'd0, ($countones(sels) <= 1)}, 32'd1);
            chk("sel_value", {24'd0, sels}, {24'd0, (in_flight ? exp_sel : 8'h00)});
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] ed;
        logic [3:0]   ef;
        logic         ee;
        int           el, lat, guard;
        logic [20:0]  snap;
        model(op, a, b, ed, ef, ee, el);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 4'($urandom); req_a = W'($urandom); req_b = W'($urandom);
        exp_sel = sel_model(op);
        in_flight = 1'b1;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_flight = 1'b0;
        chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        chk("latency", lat, el);
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, ed});
        chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, ef});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
        snap = {rsp_data, rsp_flags, rsp_err};
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_stable", {11'd0, rsp_data, rsp_flags, rsp_err}, {11'd0, snap});
            chk("hold_not_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_released", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] md;
        logic [3:0]   mf;
        logic         me;
        int           ml;

        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 4'h0; req_a = '0; req_b = '0;

        // Pin the model against hand-computed values
        model(4'd1, 16'h7FFF, 16'h0001, md, mf, me, ml);
        chk("pin_add", {12'd0, md, mf}, {12'd0, 16'h8000, 4'b0101});
        model(4'd2, 16'h0000, 16'h0001, md, mf, me, ml);
        chk("pin_sub", {12'd0, md, mf}, {12'd0, 16'hFFFF, 4'b0110});
        model(4'd9, 16'h0101, 16'hFFFF, md, mf, me, ml);
        chk("pin_mul", {md, 16'(ml)}, {16'hFEFF, 16'd16});
        model(4'd9, 16'h0003, 16'h0005, md, mf, me, ml);
        chk("pin_mul_lat", {md, 16'(ml)}, {16'h000F, 16'd3});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {14'd0, req_ready, rsp_valid, rsp_err, alu_passthrough, sels, rsp_flags}, 32'd0);
        chk("rst_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_bus", {alu_bus1, alu_bus2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Directed cases
        run_op(4'd1, 16'h7FFF, 16'h0001, 0);
        run_op(4'd2, 16'h0005, 16'h0005, 1);
        run_op(4'd2, 16'h0000, 16'h0001, 0);
        run_op(4'd9, 16'h0003, 16'h0005, 0);
        run_op(4'd9, 16'h0101, 16'hFFFF, 2);
        run_op(4'd9, 16'hABCD, 16'h0000, 0);
        run_op(4'hF, 16'h1234, 16'h5678, 0);
        run_op(4'd4, 16'h0001, 16'h0010, 5);
        run_op(4'd5, 16'hF0F0, 16'h3C3C, 0);
        run_op(4'd0, 16'h8001, 16'h0000, 0);
        run_op(4'd8, 16'h00FF, 16'h0000, 0);
        run_op(4'd3, 16'h8000, 16'h000F, 0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [3:0]   op;
            logic [W-1:0] ra, rb;
            op = 4'($urandom_range(0, 15));
            if (op > 4'd9 && ($urandom_range(0, 3) != 0)) op = 4'($urandom_range(0, 9));
            ra = W'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 20)) : W'($urandom);
            run_op(op, ra, rb, int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a MUL
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_op = 4'd9; req_a = 16'h1234; req_b = 16'hFFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_sel = 8'h01;
        in_flight = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_flight = 1'b0;
        #1;
        chk("midrst_ctrl", {14'd0, req_ready, rsp_valid, rsp_err, alu_passthrough, sels, rsp_flags}, 32'd0);
        chk("midrst_data", {16'd0, rsp_data}, 32'd0);
        chk("midrst_bus", {alu_bus1, alu_bus2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", {30'd0, req_ready, rsp_valid}, 32'd2);
        run_op(4'd1, 16'h0001, 16'h0002, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_sequencer
`default_nettype wire
